// File: rtl/uart_cmd_sched_if.sv
// Bus between the UART receiver / frame timer and the command scheduler.
// The receiver side drives the strobes; the scheduler drives the game controls.
interface uart_cmd_sched_if #(
   parameter int c_CNT_W = 3
);
   logic               i_RX_DV;
   logic [7:0]         i_RX_BYTE;
   logic               i_RX_PARITY_ERR;
   logic               i_FRAME_TICK;
   logic               o_P1_UP;
   logic               o_P1_DN;
   logic               o_P2_UP;
   logic               o_P2_DN;
   logic               o_PAUSE;
   logic               o_GAME_RST;
   logic [c_CNT_W-1:0] o_FIFO_COUNT;
   logic [7:0]         o_DROP_CNT;
   logic [7:0]         o_PERR_CNT;

   modport master (
      output i_RX_DV, i_RX_BYTE, i_RX_PARITY_ERR, i_FRAME_TICK,
      input  o_P1_UP, o_P1_DN, o_P2_UP, o_P2_DN, o_PAUSE, o_GAME_RST,
      input  o_FIFO_COUNT, o_DROP_CNT, o_PERR_CNT
   );

   modport slave (
      input  i_RX_DV, i_RX_BYTE, i_RX_PARITY_ERR, i_FRAME_TICK,
      output o_P1_UP, o_P1_DN, o_P2_UP, o_P2_DN, o_PAUSE, o_GAME_RST,
      output o_FIFO_COUNT, o_DROP_CNT, o_PERR_CNT
   );
endinterface

// File: rtl/uart_cmd_sched.sv
// Decodes UART command bytes into Pong controls; paddle moves are queued and released one per frame tick.
// Optional build macro PARITY_CHECK_EN: discard bytes flagged with a parity error and count them.
//
// state     | meaning
// s_IDLE    | move queue empty
// s_PENDING | queue holds moves, waiting for an unpaused frame tick
// s_ISSUE   | one move pulse on the outputs, queue head popped this cycle
module uart_cmd_sched #(
   parameter int c_FIFO_DEPTH = 4,
   parameter int c_CNT_W      = 3
) (
   input logic               i_CLK,
   input logic               i_RST_N,
   uart_cmd_sched_if.slave   bus
);
   localparam int c_PTR_W = $clog2(c_FIFO_DEPTH);

   localparam logic [1:0] s_IDLE    = 2'd0;
   localparam logic [1:0] s_PENDING = 2'd1;
   localparam logic [1:0] s_ISSUE   = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         r_mem [c_FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               r_pause;
   logic               r_game_rst;
   logic [3:0]         r_move;
   logic [7:0]         r_drop_cnt;
   logic [7:0]         r_perr_cnt;

   logic               w_byte_ok;
   logic               w_perr_hit;
   logic               w_is_move;
   logic               w_is_pause;
   logic               w_is_rst;
   logic               w_is_other;
   logic [1:0]         w_move_code;
   logic               w_issuing;
   logic               w_full;
   logic               w_push;
   logic               w_pop;
   logic               w_drop;
   logic               w_start_issue;
   logic [c_CNT_W-1:0] w_count_nxt;

`ifdef PARITY_CHECK_EN
   assign w_perr_hit = bus.i_RX_DV & bus.i_RX_PARITY_ERR;
   assign w_byte_ok  = bus.i_RX_DV & ~bus.i_RX_PARITY_ERR;
`else
   logic w_unused_perr;
   assign w_unused_perr = bus.i_RX_PARITY_ERR;
   assign w_perr_hit    = 1'b0;
   assign w_byte_ok     = bus.i_RX_DV;
`endif

   // Move codes double as the bit index into r_move: P1 up, P1 down, P2 up, P2 down.
   always_comb begin
      w_is_move   = 1'b0;
      w_is_pause  = 1'b0;
      w_is_rst    = 1'b0;
      w_is_other  = 1'b0;
      w_move_code = 2'd0;
      if (w_byte_ok) begin
         case (bus.i_RX_BYTE)
            8'h57:   begin w_is_move = 1'b1; w_move_code = 2'd0; end
            8'h53:   begin w_is_move = 1'b1; w_move_code = 2'd1; end
            8'h49:   begin w_is_move = 1'b1; w_move_code = 2'd2; end
            8'h4B:   begin w_is_move = 1'b1; w_move_code = 2'd3; end
            8'h50:   w_is_pause = 1'b1;
            8'h52:   w_is_rst   = 1'b1;
            default: w_is_other = 1'b1;
         endcase
      end
   end

   assign w_issuing     = (r_state == s_ISSUE);
   assign w_full        = (r_count == c_CNT_W'(c_FIFO_DEPTH));
   // A full queue still accepts a move while the head is being popped.
   assign w_push        = w_is_move & (~w_full | w_issuing);
   assign w_pop         = w_issuing;
   assign w_drop        = w_is_other | (w_is_move & ~w_push);
   assign w_start_issue = (r_state == s_PENDING) & bus.i_FRAME_TICK & ~r_pause;
   assign w_count_nxt   = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

   always_ff @(posedge i_CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= w_move_code;
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         r_state    <= s_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_pause    <= 1'b0;
         r_game_rst <= 1'b0;
         r_move     <= 4'd0;
      end else begin
         r_game_rst <= 1'b0;
         r_move     <= 4'd0;
         if (w_is_rst) begin
            // Flush wins over any pop in flight; an already-raised pulse still completes.
            r_state    <= s_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pause    <= 1'b0;
            r_game_rst <= 1'b1;
         end else begin
            if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_is_pause) r_pause  <= ~r_pause;
            r_count <= w_count_nxt;
            case (r_state)
               s_IDLE: begin
                  if (w_push) r_state <= s_PENDING;
               end
               s_PENDING: begin
                  if (w_start_issue) begin
                     r_state <= s_ISSUE;
                     r_move  <= 4'd1 << r_mem[r_rd_ptr];
                  end
               end
               s_ISSUE: begin
                  r_state <= (w_count_nxt != '0) ? s_PENDING : s_IDLE;
               end
               default: r_state <= s_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         r_drop_cnt <= 8'd0;
         r_perr_cnt <= 8'd0;
      end else begin
         if (w_drop && r_drop_cnt != 8'hFF)     r_drop_cnt <= r_drop_cnt + 8'd1;
         if (w_perr_hit && r_perr_cnt != 8'hFF) r_perr_cnt <= r_perr_cnt + 8'd1;
      end
   end

   assign bus.o_P1_UP      = r_move[0];
   assign bus.o_P1_DN      = r_move[1];
   assign bus.o_P2_UP      = r_move[2];
   assign bus.o_P2_DN      = r_move[3];
   assign bus.o_PAUSE      = r_pause;
   assign bus.o_GAME_RST   = r_game_rst;
   assign bus.o_FIFO_COUNT = r_count;
   assign bus.o_DROP_CNT   = r_drop_cnt;
   assign bus.o_PERR_CNT   = r_perr_cnt;
endmodule

// File: tb/tb_uart_cmd_sched.sv
// Bench for uart_cmd_sched: directed scenarios plus random byte/tick traffic against a queue-based model.
// Honours PARITY_CHECK_EN the same way as the design.
module tb_uart_cmd_sched;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_cmd_sched_if #(.c_CNT_W(CNT_W)) bus ();

   uart_cmd_sched #(.c_FIFO_DEPTH(DEPTH), .c_CNT_W(CNT_W)) dut (
      .i_CLK   (clk),
      .i_RST_N (rst_n),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: queued moves (0=P1 up, 1=P1 down, 2=P2 up, 3=P2 down) and what the outputs show this cycle.
   int m_q[$];
   int m_pulse;
   bit m_pause;
   bit m_grst;
   int m_drop;
   int m_perr;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int move_code(input logic [7:0] b);
      case (b)
         8'h57:   return 0;
         8'h53:   return 1;
         8'h49:   return 2;
         8'h4B:   return 3;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pulse = -1;
      m_pause = 0;
      m_grst  = 0;
      m_drop  = 0;
      m_perr  = 0;
   endtask

   task automatic model_step(input bit dv, input logic [7:0] b, input bit perr, input bit tick);
      bit issuing   = (m_pulse >= 0);
      int pre       = m_q.size();
      bit old_pause = m_pause;
      bit ok        = dv;
      int nxt       = -1;
      int code;
`ifdef PARITY_CHECK_EN
      if (dv && perr) begin
         ok = 0;
         if (m_perr < 255) m_perr++;
      end
`endif
      m_grst = 0;
      if (ok && b == 8'h52) begin
         m_q.delete();
         m_pause = 0;
         m_grst  = 1;
      end else begin
         if (!issuing && pre > 0 && tick && !old_pause) nxt = m_q[0];
         if (issuing) void'(m_q.pop_front());
         if (ok) begin
            code = move_code(b);
            if (code >= 0) begin
               if (pre == DEPTH && !issuing) begin
                  if (m_drop < 255) m_drop++;
               end else m_q.push_back(code);
            end else if (b == 8'h50) m_pause = !m_pause;
            else if (m_drop < 255) m_drop++;
         end
      end
      m_pulse = nxt;
   endtask

   task automatic compare();
      logic [31:0] mv;
      logic [31:0] mv_exp;
      mv     = {28'd0, bus.o_P2_DN, bus.o_P2_UP, bus.o_P1_DN, bus.o_P1_UP};
      mv_exp = (m_pulse < 0) ? 32'd0 : (32'd1 << m_pulse);
      check_val("move_pulses", mv, mv_exp);
      check_val("pause",       {31'd0, bus.o_PAUSE}, {31'd0, m_pause});
      check_val("game_rst",    {31'd0, bus.o_GAME_RST}, {31'd0, m_grst});
      check_val("fifo_count",  {29'd0, bus.o_FIFO_COUNT}, m_q.size());
      check_val("drop_cnt",    {24'd0, bus.o_DROP_CNT}, m_drop);
      check_val("perr_cnt",    {24'd0, bus.o_PERR_CNT}, m_perr);
   endtask

   task automatic cyc(input bit dv, input logic [7:0] b, input bit perr, input bit tick);
      @(negedge clk);
      compare();
      bus.i_RX_DV         = dv;
      bus.i_RX_BYTE       = b;
      bus.i_RX_PARITY_ERR = perr;
      bus.i_FRAME_TICK    = tick;
      model_step(dv, b, perr, tick);
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic tick();
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic rand_cycle();
      bit          dv   = ($urandom_range(0, 9) < 4);
      bit          perr = ($urandom_range(0, 9) == 0);
      bit          tk   = ($urandom_range(0, 3) == 0);
      int          sel  = $urandom_range(0, 19);
      logic [7:0]  b;
      case (sel)
         0, 1, 2, 3: b = 8'h57;
         4, 5, 6:    b = 8'h53;
         7, 8, 9:    b = 8'h49;
         10, 11, 12: b = 8'h4B;
         13:         b = 8'h50;
         14:         b = 8'h52;
         default:    b = 8'($urandom_range(0, 255));
      endcase
      cyc(dv, b, perr, tk);
   endtask

   initial begin
      bus.i_RX_DV         = 1'b0;
      bus.i_RX_BYTE       = 8'h00;
      bus.i_RX_PARITY_ERR = 1'b0;
      bus.i_FRAME_TICK    = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare();
      rst_n = 1'b1;

      // Single move: pulse two cycles after the byte.
      send(8'h57); tick(); idle(3);
      // Burst overfills the queue, then drain in order.
      send(8'h49); send(8'h4B); send(8'h53); send(8'h57); send(8'h57);
      for (int i = 0; i < 4; i++) begin tick(); idle(2); end
      // Pause holds the queue.
      send(8'h50); tick(); tick(); tick(); send(8'h57); tick(); idle(1);
      send(8'h50); tick(); idle(3);
      // Restart flushes queued moves.
      send(8'h57); send(8'h53); send(8'h49); send(8'h52); tick(); tick(); tick(); idle(1);
      // Push into a full queue during the issue cycle.
      send(8'h57); send(8'h53); send(8'h49); send(8'h4B); tick(); send(8'h53); idle(1);
      for (int i = 0; i < 4; i++) begin tick(); idle(1); end
      // Restart arriving in the issue cycle: pulse completes, queue flushed.
      send(8'h57); send(8'h4B); tick(); send(8'h52); tick(); idle(2);
      // Parity-flagged restart and an undecodable byte.
      cyc(1'b1, 8'h52, 1'b1, 1'b0); idle(1); send(8'h41); idle(2);

      for (int i = 0; i < 6000; i++) rand_cycle();

      // Async reset while a move pulse is on the outputs.
      send(8'h52); send(8'h57); send(8'h53); send(8'h49); tick();
      @(negedge clk);
      compare();
      bus.i_RX_DV      = 1'b0;
      bus.i_FRAME_TICK = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      compare();
      @(negedge clk);
      compare();
      rst_n = 1'b1;

      for (int i = 0; i < 1500; i++) rand_cycle();
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
